imm_gen_stage: RTL and testbench

//  Pipelined, parametrised immediate generator for the decode stage. Accepts

---
 rtl/imm_gen_stage_if.sv | 27 ++
 rtl/imm_gen_stage.sv | 127 ++++++++++++
 tb/tb_imm_gen_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_stage_if.sv
// Decode-stage immediate generator bus: an input request channel and an output result channel.
// The stage connects to the slave modport, and the driving environment connects to the master modport.
interface imm_gen_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      Inst;
    logic [2:0]       ImmSrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  ImmExt;
    logic [TAG_W-1:0] out_tag;
    logic             imm_err;

    modport master (
        output in_valid, Inst, ImmSrc, in_tag, out_ready,
        input  in_ready, out_valid, ImmExt, out_tag, imm_err
    );

    modport slave (
        input  in_valid, Inst, ImmSrc, in_tag, out_ready,
        output in_ready, out_valid, ImmExt, out_tag, imm_err
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: extracts and extends the immediate, then queues the result.
// The queue is a 2-entry skid buffer, so ID->EX back-pressure never drops a result.
module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    imm_gen_stage_if.slave    bus
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    entry_t          head_q, head_d;
    entry_t          tail_q, tail_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [XLEN-1:0] imm_c;
    logic            err_c;
    entry_t          new_c;
    logic            push_c;
    logic            pop_c;

    // Immediate extraction; Inst[k] holds instr[k+7]
    always_comb begin
        imm_c = '0;
        err_c = 1'b0;
        case (bus.ImmSrc)
            3'b000:  imm_c = XLEN'($signed(bus.Inst[24:13]));
            3'b001:  imm_c = XLEN'($signed({bus.Inst[24:18], bus.Inst[4:0]}));
            3'b010:  imm_c = XLEN'($signed({bus.Inst[24], bus.Inst[0], bus.Inst[23:18],
                                             bus.Inst[4:1], 1'b0}));
            3'b011:  imm_c = XLEN'($signed({bus.Inst[24], bus.Inst[12:5], bus.Inst[13],
                                             bus.Inst[23:14], 1'b0}));
            3'b100:  imm_c = XLEN'($signed({bus.Inst[24:5], 12'b0}));
            3'b101:  imm_c = (XLEN == 64) ? XLEN'(bus.Inst[18:13]) : XLEN'(bus.Inst[17:13]);
            3'b110:  imm_c = XLEN'(bus.Inst[12:8]);
            default: err_c = 1'b1;
        endcase
    end

    assign new_c  = '{imm: imm_c, tag: bus.in_tag, err: err_c};
    assign push_c = bus.in_valid & in_ready_q;
    assign pop_c  = out_valid_q & bus.out_ready;

    // Queue occupancy control; flush overrides push and pop
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = S_EMPTY;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push_c) begin
                        state_d = S_ONE;
                        head_d  = new_c;
                    end
                end
                S_ONE: begin
                    if (push_c && pop_c) begin
                        head_d = new_c;
                    end else if (push_c) begin
                        state_d = S_FULL;
                        tail_d  = new_c;
                    end else if (pop_c) begin
                        state_d = S_EMPTY;
                        head_d  = '0;
                    end
                end
                S_FULL: begin
                    if (pop_c) begin
                        state_d = S_ONE;
                        head_d  = tail_q;
                        tail_d  = '0;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    head_d  = '0;
                    tail_d  = '0;
                end
            endcase
        end
        in_ready_d  = (state_d != S_FULL);
        out_valid_d = (state_d != S_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ImmExt    = head_q.imm;
    assign bus.out_tag   = head_q.tag;
    assign bus.imm_err   = head_q.err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage covering XLEN=32 and XLEN=64 decode, queue back-pressure,
// flush, and reset.
module tb_imm_gen_stage;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32), .TAG_W(5)) a32 ();
    imm_gen_stage_if #(.XLEN(64), .TAG_W(5)) a64 ();

    imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .bus(a32.slave)
    );
    imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .bus(a64.slave)
    );

    // XLEN=32 directed vectors: ImmSrc, Inst, expected ImmExt, expected imm_err
    localparam int N32 = 11;
    logic [2:0]  s32 [N32] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b011,
                               3'b110, 3'b101, 3'b111, 3'b011, 3'b010};
    logic [24:0] i32 [N32] = '{25'h003C00A, 25'h1FFE000, 25'h0000001, 25'h0000020,
                               25'h000001F, 25'h0002000, 25'h0001F00, 25'h0040000,
                               25'h1FFFFFF, 25'h1000000, 25'h1000000};
    logic [31:0] e32 [N32] = '{32'h0000001E, 32'hFFFFFFFF, 32'h00000800, 32'h00001000,
                               32'h0000001F, 32'h00000800, 32'h0000001F, 32'h00000000,
                               32'h00000000, 32'hFFF00000, 32'hFFFFF000};
    logic        r32 [N32] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b0};

    localparam int N64 = 5;
    logic [2:0]  s64 [N64] = '{3'b100, 3'b101, 3'b111, 3'b000, 3'b101};
    logic [24:0] i64 [N64] = '{25'h1000000, 25'h0040000, 25'h0000000, 25'h1FFE000, 25'h007E000};
    logic [63:0] e64 [N64] = '{64'hFFFFFFFF80000000, 64'h20, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h3F};
    logic        r64 [N64] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive an I-type push whose immediate equals its tag
    task automatic drive_tag32(input logic [4:0] t);
        a32.in_valid = 1'b1;
        a32.ImmSrc   = 3'b000;
        a32.Inst     = {7'd0, t, 13'd0};
        a32.in_tag   = t;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        a32.in_valid = 1'b0; a32.Inst = '0; a32.ImmSrc = '0; a32.in_tag = '0; a32.out_ready = 1'b0;
        a64.in_valid = 1'b0; a64.Inst = '0; a64.ImmSrc = '0; a64.in_tag = '0; a64.out_ready = 1'b0;
        @(negedge clk);
        step();
        chk("rst_out_valid", 64'(a32.out_valid), 64'd0);
        chk("rst_in_ready",  64'(a32.in_ready),  64'd1);
        chk("rst_immext",    64'(a32.ImmExt),    64'd0);
        chk("rst_tag",       64'(a32.out_tag),   64'd0);
        reset = 1'b0;
        step();

        // Streaming decode at full rate, XLEN=32
        a32.out_ready = 1'b1;
        for (int i = 0; i < N32; i++) begin
            a32.in_valid = 1'b1;
            a32.ImmSrc   = s32[i];
            a32.Inst     = i32[i];
            a32.in_tag   = 5'(i + 3);
            step();
            chk($sformatf("x32_valid[%0d]", i), 64'(a32.out_valid), 64'd1);
            chk($sformatf("x32_imm[%0d]", i),   64'(a32.ImmExt),    64'(e32[i]));
            chk($sformatf("x32_tag[%0d]", i),   64'(a32.out_tag),   64'(i + 3));
            chk($sformatf("x32_err[%0d]", i),   64'(a32.imm_err),   64'(r32[i]));
        end
        a32.in_valid = 1'b0;
        step();
        chk("x32_drain_valid", 64'(a32.out_valid), 64'd0);
        chk("x32_drain_imm",   64'(a32.ImmExt),    64'd0);

        // Back-pressure: tags 1,2,3 with consumer stalled
        a32.out_ready = 1'b0;
        drive_tag32(5'd1);
        step();
        chk("bp_ready_after1", 64'(a32.in_ready), 64'd1);
        drive_tag32(5'd2);
        step();
        chk("bp_ready_after2", 64'(a32.in_ready), 64'd0);
        drive_tag32(5'd3);
        step();
        chk("bp_ready_hold",  64'(a32.in_ready), 64'd0);
        chk("bp_head_stable", 64'(a32.out_tag),  64'd1);
        chk("bp_imm_stable",  64'(a32.ImmExt),   64'd1);
        a32.out_ready = 1'b1;
        step();
        chk("bp_out2_tag",   64'(a32.out_tag),  64'd2);
        chk("bp_out2_ready", 64'(a32.in_ready), 64'd1);
        step();
        a32.in_valid = 1'b0;
        chk("bp_out3_tag",   64'(a32.out_tag),   64'd3);
        chk("bp_out3_imm",   64'(a32.ImmExt),    64'd3);
        chk("bp_out3_valid", 64'(a32.out_valid), 64'd1);
        step();
        chk("bp_empty", 64'(a32.out_valid), 64'd0);

        // Flush with a full queue and a pending push
        a32.out_ready = 1'b0;
        drive_tag32(5'd4);
        step();
        drive_tag32(5'd5);
        step();
        drive_tag32(5'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        a32.in_valid = 1'b0;
        chk("fl_full_valid", 64'(a32.out_valid), 64'd0);
        chk("fl_full_ready", 64'(a32.in_ready),  64'd1);
        chk("fl_full_tag",   64'(a32.out_tag),   64'd0);
        // Flush while a push is accepted on a one-entry queue
        drive_tag32(5'd7);
        step();
        drive_tag32(5'd8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        a32.in_valid = 1'b0;
        chk("fl_one_valid", 64'(a32.out_valid), 64'd0);
        step();
        chk("fl_one_still_empty", 64'(a32.out_valid), 64'd0);

        // Reset mid-stream with a full queue
        drive_tag32(5'd9);
        step();
        drive_tag32(5'd10);
        step();
        a32.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rs_valid", 64'(a32.out_valid), 64'd0);
        chk("rs_ready", 64'(a32.in_ready),  64'd1);
        chk("rs_imm",   64'(a32.ImmExt),    64'd0);
        chk("rs_tag",   64'(a32.out_tag),   64'd0);
        chk("rs_err",   64'(a32.imm_err),   64'd0);
        a32.out_ready = 1'b1;
        drive_tag32(5'd11);
        step();
        a32.in_valid = 1'b0;
        chk("rs_fresh_valid", 64'(a32.out_valid), 64'd1);
        chk("rs_fresh_tag",   64'(a32.out_tag),   64'd11);
        step();

        // XLEN=64 decode
        a64.out_ready = 1'b1;
        for (int i = 0; i < N64; i++) begin
            a64.in_valid = 1'b1;
            a64.ImmSrc   = s64[i];
            a64.Inst     = i64[i];
            a64.in_tag   = 5'(i + 1);
            step();
            chk($sformatf("x64_valid[%0d]", i), 64'(a64.out_valid), 64'd1);
            chk($sformatf("x64_imm[%0d]", i),   a64.ImmExt,         e64[i]);
            chk($sformatf("x64_tag[%0d]", i),   64'(a64.out_tag),   64'(i + 1));
            chk($sformatf("x64_err[%0d]", i),   64'(a64.imm_err),   64'(r64[i]));
        end
        a64.in_valid = 1'b0;
        step();
        chk("x64_drain_valid", 64'(a64.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
